// File: rtl/median_window_scanner_pkg.sv
// Shared constants, scanner state encoding and edge-clamp helper for the median window scanner.
package median_pkg;

    localparam int ADDR_W              = 8;
    localparam int DEFAULT_WINDOW_SIZE = 3;
    localparam int CENTER_OFFSET       = DEFAULT_WINDOW_SIZE / 2;
    localparam int WINDOW_PIXELS       = DEFAULT_WINDOW_SIZE * DEFAULT_WINDOW_SIZE;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FLUSH,
        DONE
    } scanState_t;

    // Clamp a signed position into [0, maxPos] and return it as an unsigned address.
    function automatic logic [ADDR_W-1:0] clampToEdge(input logic signed [ADDR_W+1:0] pos,
                                                      input logic signed [ADDR_W+1:0] maxPos);
        if (pos[ADDR_W+1])
            return '0;
        else if (pos > maxPos)
            return maxPos[ADDR_W-1:0];
        else
            return pos[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/median_window_scanner_if.sv
// Frame-buffer read port plus window stream toward the median processor.
interface median_window_scanner_if;

    logic                           rdEn;
    logic [median_pkg::ADDR_W-1:0]  rdAddrX;
    logic [median_pkg::ADDR_W-1:0]  rdAddrY;
    logic                           rdData;
    logic                           dataValid;
    logic                           dataOut;
    logic [median_pkg::ADDR_W-1:0]  xAddressOut;
    logic [median_pkg::ADDR_W-1:0]  yAddressOut;

    modport master (
        output rdEn, rdAddrX, rdAddrY,
        input  rdData,
        output dataValid, dataOut, xAddressOut, yAddressOut
    );

    modport slave (
        input  rdEn, rdAddrX, rdAddrY,
        output rdData,
        input  dataValid, dataOut, xAddressOut, yAddressOut
    );

endinterface

// File: rtl/median_window_scanner_offset.sv
// Row/column offset counters inside one window; wraps after the last pixel and flags it.
module window_offset_counter
    import median_pkg::*;
#(
    parameter int WINDOW_SIZE = DEFAULT_WINDOW_SIZE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    output logic [ADDR_W-1:0] rowOff,
    output logic [ADDR_W-1:0] colOff,
    output logic              lastPixel
);

    localparam logic [ADDR_W-1:0] LAST_OFF = ADDR_W'(WINDOW_SIZE - 1);

    // Column offset is the inner loop; the row offset steps when the column wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rowOff <= '0;
            colOff <= '0;
        end else if (clear) begin
            rowOff <= '0;
            colOff <= '0;
        end else if (advance) begin
            if (colOff == LAST_OFF) begin
                colOff <= '0;
                rowOff <= (rowOff == LAST_OFF) ? '0 : rowOff + 1'b1;
            end else begin
                colOff <= colOff + 1'b1;
            end
        end
    end

    assign lastPixel = (rowOff == LAST_OFF) && (colOff == LAST_OFF);

endmodule

// File: rtl/median_window_scanner.sv
// Walks the frame buffer window by window and streams each window to the median stage.
// Optional MEDIAN_BORDER_PAD_EN: scan every pixel as a center, zero-padding outside the image.
module median_window_scanner
    import median_pkg::*;
#(
    parameter int WINDOW_SIZE = DEFAULT_WINDOW_SIZE,
    parameter int IMG_WIDTH   = 128,
    parameter int IMG_HEIGHT  = 128
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    median_window_scanner_if.master pixelBus
);

    localparam int OFF = WINDOW_SIZE / 2;

`ifdef MEDIAN_BORDER_PAD_EN
    localparam int   CX_MIN     = 0;
    localparam int   CX_MAX     = IMG_WIDTH - 1;
    localparam int   CY_MIN     = 0;
    localparam int   CY_MAX     = IMG_HEIGHT - 1;
    localparam logic NO_WINDOWS = 1'b0;
    // One spare bit beyond sign+8 so center+OFF at the 255 edge cannot wrap.
    localparam int   SW         = ADDR_W + 2;
    localparam logic signed [SW-1:0] OFF_S   = SW'(OFF);
    localparam logic signed [SW-1:0] X_MAX_S = SW'(IMG_WIDTH - 1);
    localparam logic signed [SW-1:0] Y_MAX_S = SW'(IMG_HEIGHT - 1);
`else
    localparam int   CX_MIN     = OFF;
    localparam int   CX_MAX     = IMG_WIDTH - 1 - OFF;
    localparam int   CY_MIN     = OFF;
    localparam int   CY_MAX     = IMG_HEIGHT - 1 - OFF;
    localparam logic NO_WINDOWS = (IMG_WIDTH < WINDOW_SIZE) || (IMG_HEIGHT < WINDOW_SIZE);
    localparam logic [ADDR_W-1:0] OFF_A = ADDR_W'(OFF);
`endif

    localparam logic [ADDR_W-1:0] CX_FIRST = ADDR_W'(CX_MIN);
    localparam logic [ADDR_W-1:0] CX_LAST  = ADDR_W'(CX_MAX);
    localparam logic [ADDR_W-1:0] CY_FIRST = ADDR_W'(CY_MIN);
    localparam logic [ADDR_W-1:0] CY_LAST  = ADDR_W'(CY_MAX);

    scanState_t        state;
    scanState_t        nextState;
    logic              scanning;
    logic [ADDR_W-1:0] cx;
    logic [ADDR_W-1:0] cy;
    logic [ADDR_W-1:0] rowOff;
    logic [ADDR_W-1:0] colOff;
    logic              lastPixel;
    logic              lastCenter;
    logic              inImage;
    logic [ADDR_W-1:0] pixAddrX;
    logic [ADDR_W-1:0] pixAddrY;
    logic [ADDR_W-1:0] anchorX;
    logic [ADDR_W-1:0] anchorY;
    logic              dataValidQ;
    logic              readQ;
    logic [ADDR_W-1:0] xAddrQ;
    logic [ADDR_W-1:0] yAddrQ;

    window_offset_counter #(
        .WINDOW_SIZE (WINDOW_SIZE)
    ) offsetCounter (
        .clk       (clk),
        .reset     (reset),
        .clear     (state == IDLE),
        .advance   (scanning),
        .rowOff    (rowOff),
        .colOff    (colOff),
        .lastPixel (lastPixel)
    );

    assign lastCenter = (cx == CX_LAST) && (cy == CY_LAST);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= nextState;
    end

    // Next-state logic; an empty frame skips SCAN but still spends one busy cycle in FLUSH.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = NO_WINDOWS ? FLUSH : SCAN;
            SCAN:    if (lastPixel && lastCenter) nextState = FLUSH;
            FLUSH:   nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        scanning = (state == SCAN);
        busy     = (state == SCAN) || (state == FLUSH);
        done     = (state == DONE);
    end

    // Window centers advance in raster order once the current window's last pixel is read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cx <= '0;
            cy <= '0;
        end else if (state == IDLE && start) begin
            cx <= CX_FIRST;
            cy <= CY_FIRST;
        end else if (scanning && lastPixel) begin
            if (cx == CX_LAST) begin
                cx <= CX_FIRST;
                cy <= cy + 1'b1;
            end else begin
                cx <= cx + 1'b1;
            end
        end
    end

    // Pixel address and anchor for the read issued this cycle.
    always_comb begin
        inImage  = 1'b1;
        pixAddrX = '0;
        pixAddrY = '0;
        anchorX  = '0;
        anchorY  = '0;
`ifdef MEDIAN_BORDER_PAD_EN
        begin
            logic signed [SW-1:0] posX;
            logic signed [SW-1:0] posY;
            posX     = $signed({2'b00, cx}) - OFF_S + $signed({2'b00, colOff});
            posY     = $signed({2'b00, cy}) - OFF_S + $signed({2'b00, rowOff});
            inImage  = !posX[SW-1] && !posY[SW-1] && (posX <= X_MAX_S) && (posY <= Y_MAX_S);
            pixAddrX = posX[ADDR_W-1:0];
            pixAddrY = posY[ADDR_W-1:0];
            anchorX  = clampToEdge($signed({2'b00, cx}) + OFF_S, X_MAX_S);
            anchorY  = clampToEdge($signed({2'b00, cy}) + OFF_S, Y_MAX_S);
        end
`else
        pixAddrX = cx - OFF_A + colOff;
        pixAddrY = cy - OFF_A + rowOff;
        anchorX  = cx + OFF_A;
        anchorY  = cy + OFF_A;
`endif
    end

    // One-stage output register lining the anchor up with the pixel returned next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dataValidQ <= 1'b0;
            readQ      <= 1'b0;
            xAddrQ     <= '0;
            yAddrQ     <= '0;
        end else begin
            dataValidQ <= scanning;
            readQ      <= scanning && inImage;
            if (scanning) begin
                xAddrQ <= anchorX;
                yAddrQ <= anchorY;
            end
        end
    end

    assign pixelBus.rdEn        = scanning && inImage;
    assign pixelBus.rdAddrX     = scanning ? pixAddrX : '0;
    assign pixelBus.rdAddrY     = scanning ? pixAddrY : '0;
    assign pixelBus.dataValid   = dataValidQ;
    assign pixelBus.dataOut     = readQ && pixelBus.rdData;
    assign pixelBus.xAddressOut = xAddrQ;
    assign pixelBus.yAddressOut = yAddrQ;

endmodule

// File: tb/tb_median_window_scanner.sv
// Randomized image scans compared beat-by-beat against a window-enumeration reference model.
module tb_median_window_scanner;

    localparam int WS  = 3;
    localparam int W   = 5;
    localparam int H   = 5;
    localparam int OFF = WS / 2;

    typedef struct {
        bit rd;
        int rx;
        int ry;
        bit px;
        int ax;
        int ay;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic busy, done;
    logic zStart = 1'b0;
    logic zBusy, zDone;
    int   checks = 0;
    int   failures = 0;
    bit   img [H][W];
    beat_t expQ[$];

    median_window_scanner_if bus ();
    median_window_scanner_if zBus ();

    median_window_scanner #(.WINDOW_SIZE(WS), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .pixelBus (bus)
    );

    median_window_scanner #(.WINDOW_SIZE(WS), .IMG_WIDTH(2), .IMG_HEIGHT(2)) zDut (
        .clk      (clk),
        .reset    (reset),
        .start    (zStart),
        .busy     (zBusy),
        .done     (zDone),
        .pixelBus (zBus)
    );

    always #5 clk = ~clk;

    // Synchronous-read frame buffer.
    always @(posedge clk) begin
        if (bus.rdEn && bus.rdAddrX < W && bus.rdAddrY < H)
            bus.rdData <= img[int'(bus.rdAddrY)][int'(bus.rdAddrX)];
    end
    assign zBus.rdData = 1'b0;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Enumerate every window and every pixel in the order the consumer expects.
    task automatic buildExpected();
        int cxLo, cxHi, cyLo, cyHi;
        beat_t b;
        expQ.delete();
`ifdef MEDIAN_BORDER_PAD_EN
        cxLo = 0; cxHi = W - 1; cyLo = 0; cyHi = H - 1;
`else
        cxLo = OFF; cxHi = W - 1 - OFF; cyLo = OFF; cyHi = H - 1 - OFF;
`endif
        for (int cy = cyLo; cy <= cyHi; cy++)
            for (int cx = cxLo; cx <= cxHi; cx++)
                for (int dy = 0; dy < WS; dy++)
                    for (int dx = 0; dx < WS; dx++) begin
                        b.rx = cx - OFF + dx;
                        b.ry = cy - OFF + dy;
                        b.rd = (b.rx >= 0) && (b.rx < W) && (b.ry >= 0) && (b.ry < H);
                        b.px = b.rd ? img[b.ry][b.rx] : 1'b0;
                        b.ax = (cx + OFF > W - 1) ? W - 1 : cx + OFF;
                        b.ay = (cy + OFF > H - 1) ? H - 1 : cy + OFF;
                        expQ.push_back(b);
                    end
    endtask

    task automatic applyStimulus();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic checkRead(input int k);
        checkOutput($sformatf("read%0d.rdEn", k), bus.rdEn, expQ[k].rd);
        if (expQ[k].rd) begin
            checkOutput($sformatf("read%0d.rdAddrX", k), bus.rdAddrX, expQ[k].rx);
            checkOutput($sformatf("read%0d.rdAddrY", k), bus.rdAddrY, expQ[k].ry);
        end
    endtask

    task automatic fillImage(input int mode);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                case (mode)
                    0:       img[y][x] = 1'b1;
                    1:       img[y][x] = (x == 2 && y == 2);
                    default: img[y][x] = 1'($urandom_range(1, 0));
                endcase
    endtask

    // One full scan; optional mid-scan start poke, async abort, or start during done.
    task automatic runScan(input int abortAt, input bit pokeStart, input bit startAtDone);
        int n;
        buildExpected();
        n = expQ.size();
        applyStimulus();
        checkOutput("busyAfterStart", busy, 1);
        checkRead(0);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            start = (pokeStart && k == 10);
            checkOutput($sformatf("beat%0d.dataValid", k), bus.dataValid, 1);
            checkOutput($sformatf("beat%0d.dataOut", k), bus.dataOut, expQ[k].px);
            checkOutput($sformatf("beat%0d.xAddressOut", k), bus.xAddressOut, expQ[k].ax);
            checkOutput($sformatf("beat%0d.yAddressOut", k), bus.yAddressOut, expQ[k].ay);
            checkOutput($sformatf("beat%0d.done", k), done, 0);
            if (k + 1 < n)
                checkRead(k + 1);
            else
                checkOutput("flush.rdEn", bus.rdEn, 0);
            if (k == abortAt) begin
                reset = 1'b0;
                #1;
                checkOutput("abort.busy", busy, 0);
                checkOutput("abort.dataValid", bus.dataValid, 0);
                checkOutput("abort.rdEn", bus.rdEn, 0);
                checkOutput("abort.xAddressOut", bus.xAddressOut, 0);
                checkOutput("abort.yAddressOut", bus.yAddressOut, 0);
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("abort.done", done, 0);
                end
                reset = 1'b1;
                return;
            end
        end
        @(negedge clk);
        checkOutput("donePulse", done, 1);
        checkOutput("doneCycle.dataValid", bus.dataValid, 0);
        checkOutput("doneCycle.busy", busy, 0);
        start = startAtDone;
        @(negedge clk);
        start = 1'b0;
        checkOutput("afterDone.done", done, 0);
        checkOutput("afterDone.busy", busy, 0);
        @(negedge clk);
        checkOutput("idle.busy", busy, 0);
        checkOutput("idle.dataValid", bus.dataValid, 0);
    endtask

    initial begin
        #2;
        checkOutput("reset.busy", busy, 0);
        checkOutput("reset.done", done, 0);
        checkOutput("reset.dataValid", bus.dataValid, 0);
        checkOutput("reset.rdEn", bus.rdEn, 0);
        checkOutput("reset.xAddressOut", bus.xAddressOut, 0);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);

        fillImage(0);
        runScan(-1, 1'b0, 1'b0);
        fillImage(1);
        runScan(-1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            fillImage(2);
            runScan(-1, i == 1, 1'b0);
        end
        fillImage(2);
        runScan(20, 1'b0, 1'b0);
        @(negedge clk);
        fillImage(2);
        runScan(-1, 1'b0, 1'b0);

`ifndef MEDIAN_BORDER_PAD_EN
        @(negedge clk) zStart = 1'b1;
        @(negedge clk) zStart = 1'b0;
        checkOutput("empty.busy", zBusy, 1);
        checkOutput("empty.dataValid", zBus.dataValid, 0);
        @(negedge clk);
        checkOutput("empty.done", zDone, 1);
        checkOutput("empty.busyAtDone", zBusy, 0);
        checkOutput("empty.dataValidAtDone", zBus.dataValid, 0);
        @(negedge clk);
        checkOutput("empty.doneCleared", zDone, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
